// File: rtl/period_meter.sv
// Measures the period and high time of a slow, free-running square wave in clk_in cycles.
// Flags lock when two consecutive periods match; the timeout flag is sticky once the input stalls.
module period_meter #(
    parameter int CNT_W   = 23,
    parameter int TIMEOUT = 5000000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] prev_period;
    logic             have_prev;
    logic             rise;

    assign rise = s2 & ~s3;

    // The rising edge closes one measurement and opens the next, so a period equal to TIMEOUT still reports.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            cnt         <= '0;
            hcnt        <= '0;
            prev_period <= '0;
            have_prev   <= 1'b0;
            period      <= '0;
            high_time   <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            s1    <= sig_in;
            s2    <= s1;
            s3    <= s2;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!s2) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (rise) begin
                        cnt   <= CNT_ONE;
                        hcnt  <= CNT_ONE;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rise) begin
                        period      <= cnt;
                        high_time   <= hcnt;
                        valid       <= 1'b1;
                        timeout     <= 1'b0;
                        locked      <= have_prev && (cnt == prev_period);
                        prev_period <= cnt;
                        have_prev   <= 1'b1;
                        cnt         <= CNT_ONE;
                        hcnt        <= CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                        have_prev <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt  <= cnt + CNT_ONE;
                        hcnt <= hcnt + CNT_W'(s2);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures a slow, free-running square wave, typically the divided clock produced elsewhere in the design or an external strobe, in `clk_in` cycles. It synchronises the input, detects rising edges, and reports period and high time per cycle of the input. It flags lock when consecutive periods match and flags timeout when the input stops toggling. It is the receiving end of our clock-divider outputs, used for self-check and board bring-up.

## Interface
- `CNT_W`, default 23: width of the counters and of the `period` and `high_time` outputs; must satisfy `2^CNT_W > TIMEOUT`.
- `TIMEOUT`, default 5000000: longest measurable period in cycles; must be ≥ 2.
- `clk_in`, input, 1: sole clock; all logic on its rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `sig_in`, input, 1: asynchronous signal under measurement.
- `period`, output, CNT_W: last measured period in `clk_in` cycles.
- `high_time`, output, CNT_W: number of cycles the synchronised input was high in that period.
- `valid`, output, 1: one-cycle pulse when `period`/`high_time` update.
- `locked`, output, 1: the last two consecutive measurements had an equal `period`.
- `timeout`, output, 1: sticky; no rising edge arrived within TIMEOUT cycles.

## Operation
- Synchroniser: `s1 <= sig_in`, `s2 <= s1`, `s3 <= s2`. The edge-detect term is `rise = s2 & ~s3`; `s2` is the "synchronised input".
- FSM states:
  - IDLE: waits for `s2 == 0`, then goes to ARM. This blocks a rise caused by a high input at reset release.
  - ARM: waits for `rise`. On `rise`: `cnt <= 1`, `hcnt <= 1`, go to RUN. No `valid` is produced in ARM.
  - RUN: each cycle without `rise`: `cnt <= cnt + 1`; `hcnt <= hcnt + s2`.
- RUN on `rise`:
  - `period <= cnt`, `high_time <= hcnt`, `valid <= 1`, `timeout <= 0`.
  - Then `cnt <= 1`, `hcnt <= 1`, and the FSM stays in RUN.
- RUN timeout: on a cycle with `cnt == TIMEOUT` and no `rise`:
  - `timeout <= 1`, `locked <= 0`, `have_prev <= 0`, go to IDLE.
  - `period` and `high_time` hold their last values.
- Lock, on each `valid`:
  - If `have_prev` and the new period equals `prev_period`, then `locked <= 1`; otherwise `locked <= 0`.
  - Then `prev_period <= new period` and `have_prev <= 1`.
- Widths: `cnt` and `hcnt` are CNT_W bits. `cnt` never exceeds TIMEOUT, so no wrap occurs; `hcnt` ≤ `cnt`.
- Simultaneous `rise` and `cnt == TIMEOUT`: `rise` wins. A period equal to TIMEOUT is measured normally.
- `timeout` stays set through IDLE/ARM. It clears only on the first `valid` after recovery, i.e. at the second rising edge after the input resumes.

## Timing
- Reset values:
  - outputs: `period = 0`, `high_time = 0`, `valid = 0`, `locked = 0`, `timeout = 0`.
  - internal: `s1`, `s2`, `s3`, `cnt`, `hcnt`, `prev_period`, `have_prev` all 0; state IDLE.
- Reset asserted mid-operation clears everything immediately (asynchronous). After release, the block restarts from IDLE.
- Latency: `sig_in` sampled high at edge k puts `rise` in cycle k+1..k+2. `valid`, `period`, `high_time` and `locked` update at edge k+2.
- Input period of P cycles, high for H cycles (P ≥ 2, P ≤ TIMEOUT):
  - `valid` every P cycles, with `period = P` and `high_time = H`.
  - The first `valid` follows the second detected rise after ARM.
  - `locked` first asserts on the second `valid`.
- Timeout asserts at edge k+2+TIMEOUT when the last rise was sampled at k and no later rise arrives.
- Inputs with high or low phases shorter than one `clk_in` cycle are not supported.

## Test plan
- Clock-divider source with div=2 (P=2, H=1) driving `sig_in`:
  - `valid` every 2 cycles with `period = 2`, `high_time = 1`.
  - `locked = 1` from the second `valid` onward.
- Square wave with P=10, H=3:
  - first `valid` 2 cycles after the second rise is sampled.
  - `period = 10`, `high_time = 3`; `timeout` stays 0.
- `sig_in` held high across reset release:
  - no `valid` until `sig_in` goes low and then rises twice.
  - first report equals the true period.
- TIMEOUT=16:
  - P=16 gives `valid` with `period = 16` and `timeout = 0`.
  - P=17 sets `timeout = 1` and `locked = 0`, with `period` holding its prior value.
  - Restoring P=10 clears `timeout` on the first new `valid`.
- Period step 10→12 while locked:
  - the first 12 gives `locked = 0`.
  - the next 12 gives `locked = 1`.
- Assert `rst` mid-period while `locked = 1`:
  - all outputs go to 0 in the same cycle, without waiting for a clock edge.
  - after release, measurement restarts and `locked` returns after two `valid`s.
